// File: rtl/writeback_stage.sv
// M/W pipeline register and retirement controller: drives the register-file
// write ports, suppresses writes from faulting instructions and halts the core.
module writeback_stage #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 4,
  parameter int CNT_WID  = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2:0]          m_stat,
  input  logic [3:0]          m_icode,
  input  logic [DATA_WID-1:0] m_valE,
  input  logic [DATA_WID-1:0] m_valM,
  input  logic [ADDR_WID-1:0] m_dstE,
  input  logic [ADDR_WID-1:0] m_dstM,
  input  logic                W_stall,
  input  logic                W_bubble,
  output logic [DATA_WID-1:0] valE,
  output logic [DATA_WID-1:0] valM,
  output logic [ADDR_WID-1:0] destE,
  output logic [ADDR_WID-1:0] destM,
  output logic [2:0]          W_stat,
  output logic [3:0]          W_icode,
  output logic [CNT_WID-1:0]  retire_cnt,
  output logic                halted,
  output logic [2:0]          cpu_stat
);

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0]          ICODE_NOP = 4'h1;
  localparam logic [ADDR_WID-1:0] RNONE     = '1;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]          state;
  logic [2:0]          haltStat;
  logic [DATA_WID-1:0] wValE;
  logic [DATA_WID-1:0] wValM;
  logic [ADDR_WID-1:0] wDstE;
  logic [ADDR_WID-1:0] wDstM;
  logic                isFault;
  logic                canWrite;

  assign isFault  = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
  assign canWrite = (state == RUN) && (W_stat == STAT_AOK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      haltStat   <= STAT_AOK;
      W_stat     <= STAT_BUB;
      W_icode    <= ICODE_NOP;
      wValE      <= '0;
      wValM      <= '0;
      wDstE      <= RNONE;
      wDstM      <= RNONE;
      retire_cnt <= '0;
    end else if (state == RUN) begin
      // The faulting instruction itself never retires; the halt freezes everything after this edge.
      if (isFault) begin
        state    <= HALTED;
        haltStat <= W_stat;
      end
      if (W_stat == STAT_AOK && !W_stall) begin
        retire_cnt <= retire_cnt + CNT_WID'(1);
      end
      if (!W_stall) begin
        if (W_bubble) begin
          W_stat  <= STAT_BUB;
          W_icode <= ICODE_NOP;
          wValE   <= '0;
          wValM   <= '0;
          wDstE   <= RNONE;
          wDstM   <= RNONE;
        end else begin
          W_stat  <= m_stat;
          W_icode <= m_icode;
          wValE   <= m_valE;
          wValM   <= m_valM;
          wDstE   <= m_dstE;
          wDstM   <= m_dstM;
        end
      end
    end
  end

  assign valE     = wValE;
  assign valM     = wValM;
  assign destE    = canWrite ? wDstE : RNONE;
  assign destM    = canWrite ? wDstM : RNONE;
  assign halted   = (state == HALTED);
  assign cpu_stat = (state == HALTED) ? haltStat : STAT_AOK;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage (4-bit retire counter) against a cycle-level
// reference model of the W register, halt latch and retirement count.
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [31:0] m_valE;
  logic [31:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [31:0] valE;
  logic [31:0] valM;
  logic [3:0]  destE;
  logic [3:0]  destM;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  retire_cnt;
  logic        halted;
  logic [2:0]  cpu_stat;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DATA_WID(32), .ADDR_WID(4), .CNT_WID(4)) dut (
    .CLK(CLK), .RST(RST), .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble), .valE(valE), .valM(valM),
    .destE(destE), .destM(destM), .W_stat(W_stat), .W_icode(W_icode),
    .retire_cnt(retire_cnt), .halted(halted), .cpu_stat(cpu_stat)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model: contents of the instruction sitting in W plus core status
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic [31:0] e_valE;
  logic [31:0] e_valM;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  bit          e_halted;
  logic [2:0]  e_cpu;
  int          e_cnt;

  wire [86:0] obsOut = {valE, valM, destE, destM, W_stat, W_icode, retire_cnt, halted, cpu_stat};

  function automatic logic [86:0] expOut();
    bit writes;
    writes = !e_halted && (e_stat == 3'd1);
    return {e_valE, e_valM, writes ? e_dstE : 4'hF, writes ? e_dstM : 4'hF,
            e_stat, e_icode, 4'(e_cnt), e_halted, e_cpu};
  endfunction

  task automatic modelStep();
    bit faulting, retiring;
    if (RST) begin
      e_stat = 3'd0; e_icode = 4'h1; e_valE = '0; e_valM = '0;
      e_dstE = 4'hF; e_dstM = 4'hF; e_halted = 0; e_cpu = 3'd1; e_cnt = 0;
    end else if (!e_halted) begin
      faulting = (e_stat >= 3'd2 && e_stat <= 3'd4);
      retiring = (e_stat == 3'd1) && !W_stall;
      if (faulting) begin
        e_halted = 1;
        e_cpu = e_stat;
      end
      if (retiring) e_cnt = (e_cnt + 1) % 16;
      if (!W_stall && W_bubble) begin
        e_stat = 3'd0; e_icode = 4'h1; e_valE = '0; e_valM = '0; e_dstE = 4'hF; e_dstM = 4'hF;
      end else if (!W_stall) begin
        e_stat = m_stat; e_icode = m_icode; e_valE = m_valE; e_valM = m_valM;
        e_dstE = m_dstE; e_dstM = m_dstM;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic driveM(input logic [2:0] s, input logic [3:0] dE, input logic [3:0] dM);
    m_stat = s;
    m_icode = 4'($urandom_range(0, 15));
    m_valE = $urandom;
    m_valM = $urandom;
    m_dstE = dE;
    m_dstM = dM;
  endtask

  task automatic test_reset();
    RST = 1; W_stall = 0; W_bubble = 0;
    driveM(3'd1, 4'd3, 4'd4);
    tick();
    RST = 0;
    checks++;
    if (obsOut !== expOut()) begin
      errors++; $display("FAIL reset_all: got %h expected %h", obsOut, expOut());
    end
    checks++;
    if ({valE, valM, destE, destM, halted, cpu_stat, retire_cnt, W_stat} !==
        {32'h0, 32'h0, 4'hF, 4'hF, 1'b0, 3'd1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_values: got valE=%h valM=%h dE=%h dM=%h h=%b cs=%0d cnt=%0d st=%0d required 0 0 f f 0 1 0 0",
               valE, valM, destE, destM, halted, cpu_stat, retire_cnt, W_stat);
    end
  endtask

  task automatic test_load();
    driveM(3'd1, 4'd2, 4'hF);
    m_valE = 32'h25;
    tick();
    checks++;
    if ({valE, destE, destM} !== {32'h25, 4'd2, 4'hF}) begin
      errors++; $display("FAIL load_outputs: got %h/%h/%h required 00000025/2/f", valE, destE, destM);
    end
    driveM(3'd0, 4'hF, 4'hF);
    tick();
    checks++;
    if (retire_cnt !== 4'd1) begin
      errors++; $display("FAIL load_retire: got %0d required 1", retire_cnt);
    end
  endtask

  task automatic test_stall();
    logic [3:0] c0;
    driveM(3'd1, 4'd6, 4'd5);
    m_valM = 32'hAB;
    tick();
    c0 = retire_cnt;
    W_stall = 1;
    for (int i = 0; i < 3; i++) begin
      driveM(3'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      W_bubble = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({destM, valM, retire_cnt} !== {4'd5, 32'hAB, c0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got destM=%h valM=%h cnt=%0d required 5 ab %0d", i, destM, valM, retire_cnt, c0);
      end
    end
    W_stall = 0; W_bubble = 0;
    driveM(3'd0, 4'hF, 4'hF);
    tick();
    tick();
    checks++;
    if (retire_cnt !== c0 + 4'd1) begin
      errors++; $display("FAIL stall_retire_once: got %0d required %0d", retire_cnt, c0 + 4'd1);
    end
  endtask

  task automatic test_bubble();
    logic [3:0] c0;
    c0 = retire_cnt;
    driveM(3'd1, 4'd3, 4'd7);
    W_bubble = 1;
    tick();
    checks++;
    if ({W_stat, destE, destM, retire_cnt} !== {3'd0, 4'hF, 4'hF, c0}) begin
      errors++; $display("FAIL bubble_load: got st=%0d dE=%h dM=%h cnt=%0d required 0 f f %0d", W_stat, destE, destM, retire_cnt, c0);
    end
    W_bubble = 0;
    driveM(3'd1, 4'd9, 4'd10);
    tick();
    W_stall = 1; W_bubble = 1;
    driveM(3'd1, 4'd1, 4'd1);
    tick();
    checks++;
    if ({W_stat, destE, destM} !== {3'd1, 4'd9, 4'd10}) begin
      errors++; $display("FAIL stall_over_bubble: got st=%0d dE=%h dM=%h required 1 9 a", W_stat, destE, destM);
    end
    W_stall = 0; W_bubble = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      RST = ($urandom_range(0, 24) == 0);
      W_stall = ($urandom_range(0, 3) == 0);
      W_bubble = ($urandom_range(0, 4) == 0);
      driveM(3'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks++;
      if (obsOut !== expOut()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, obsOut, expOut());
      end
    end
    RST = 0; W_stall = 0; W_bubble = 0;
  endtask

  task automatic test_halt();
    logic [86:0] snap;
    driveM(3'd3, 4'd4, 4'd8);
    tick();
    checks++;
    if ({destE, destM, halted, W_stat} !== {4'hF, 4'hF, 1'b0, 3'd3}) begin
      errors++; $display("FAIL fault_no_write: got dE=%h dM=%h h=%b st=%0d required f f 0 3", destE, destM, halted, W_stat);
    end
    driveM(3'd1, 4'd7, 4'd6);
    tick();
    checks++;
    if ({halted, cpu_stat, destE, destM} !== {1'b1, 3'd3, 4'hF, 4'hF}) begin
      errors++; $display("FAIL halt_enter: got h=%b cs=%0d dE=%h dM=%h required 1 3 f f", halted, cpu_stat, destE, destM);
    end
    snap = obsOut;
    for (int i = 0; i < 5; i++) begin
      driveM(3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      W_stall = 1'($urandom_range(0, 1));
      W_bubble = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obsOut !== snap || obsOut !== expOut()) begin
        errors++; $display("FAIL halt_frozen%0d: got %h required %h", i, obsOut, snap);
      end
    end
    W_stall = 0; W_bubble = 0;
  endtask

  task automatic test_halt_reset();
    RST = 1;
    tick();
    RST = 0;
    checks++;
    if ({halted, cpu_stat, retire_cnt, W_stat, destE, destM} !== {1'b0, 3'd1, 4'd0, 3'd0, 4'hF, 4'hF}) begin
      errors++;
      $display("FAIL halt_reset: got h=%b cs=%0d cnt=%0d st=%0d dE=%h dM=%h required 0 1 0 0 f f",
               halted, cpu_stat, retire_cnt, W_stat, destE, destM);
    end
  endtask

  task automatic test_stall_reset();
    driveM(3'd1, 4'd2, 4'd3);
    tick();
    tick();
    W_stall = 1;
    tick();
    RST = 1;
    tick();
    RST = 0; W_stall = 0;
    checks++;
    if ({destE, destM, retire_cnt, W_stat} !== {4'hF, 4'hF, 4'd0, 3'd0}) begin
      errors++; $display("FAIL stall_reset: got dE=%h dM=%h cnt=%0d st=%0d required f f 0 0", destE, destM, retire_cnt, W_stat);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 1; n <= 18; n++) begin
      driveM((n <= 17) ? 3'd1 : 3'd0, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
      tick();
      checks++;
      if (obsOut !== expOut()) begin
        errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", n, obsOut, expOut());
      end
      if (n == 16) begin
        checks++;
        if (retire_cnt !== 4'd15) begin
          errors++; $display("FAIL wrap_15: got %0d required 15", retire_cnt);
        end
      end
    end
    checks++;
    if (retire_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_17: got %0d required 1", retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_bubble();
    test_random();
    test_halt();
    test_halt_reset();
    test_stall_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
